// File: rtl/systolic_driver_pkg.sv
// Shared types and sizes for the 3x3 systolic array driver.
package systolic_pkg;
   localparam int N        = 3;
   localparam int DATA_W   = 32;
   localparam int ACC_W    = 64;
   localparam int ELEM_CNT = 9;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_FEED   = 3'd2,
      S_DRAIN  = 3'd3,
      S_STREAM = 3'd4
   } drv_state_t;

   // Row-major element index of (r, c) in an N x N matrix.
   function automatic logic [3:0] elem_idx(input logic [1:0] r, input logic [1:0] c);
      return 4'(int'(r) * N + int'(c));
   endfunction
endpackage

// File: rtl/systolic_driver_operand_bank.sv
// 3x3 operand register file: row-major write port, three read ports selecting
// either column k of each row (sel_row=1) or row k across columns (sel_row=0).
module operand_bank
   import systolic_pkg::*;
(
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [3:0]                 wr_idx,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       sel_row,
   input  logic [1:0]                 k,
   output logic [N-1:0][DATA_W-1:0]   rd
);
   logic [ELEM_CNT-1:0][DATA_W-1:0] mem;

   // Contents survive reset so operands can be reused across runs.
   always_ff @(posedge clk) begin
      if (wr_en && wr_idx < 4'(ELEM_CNT))
         mem[wr_idx] <= wr_data;
   end

   always_comb begin
      rd = '0;
      for (int i = 0; i < N; i++)
         rd[i] = sel_row ? mem[elem_idx(2'(i), k)] : mem[elem_idx(k, 2'(i))];
   end
endmodule

// File: rtl/systolic_driver.sv
// Sequencer for the 3x3 output-stationary systolic array: loads operands,
// clears, feeds, drains, captures the nine results and streams them out.
module systolic_driver
   import systolic_pkg::*;
#(
   parameter int DRAIN_CYCLES = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic               ld_sel,
   input  logic [3:0]         ld_idx,
   input  logic [DATA_W-1:0]  ld_data,
   input  logic               start,
   output logic               busy,
   output logic               arr_rst,
   output logic [DATA_W-1:0]  arr_a1,
   output logic [DATA_W-1:0]  arr_a2,
   output logic [DATA_W-1:0]  arr_a3,
   output logic [DATA_W-1:0]  arr_b1,
   output logic [DATA_W-1:0]  arr_b2,
   output logic [DATA_W-1:0]  arr_b3,
   input  logic [ACC_W-1:0]   arr_c1,
   input  logic [ACC_W-1:0]   arr_c2,
   input  logic [ACC_W-1:0]   arr_c3,
   input  logic [ACC_W-1:0]   arr_c4,
   input  logic [ACC_W-1:0]   arr_c5,
   input  logic [ACC_W-1:0]   arr_c6,
   input  logic [ACC_W-1:0]   arr_c7,
   input  logic [ACC_W-1:0]   arr_c8,
   input  logic [ACC_W-1:0]   arr_c9,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [ACC_W-1:0]   res_data,
   output logic [3:0]         res_idx,
   output logic               res_last
);
   localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;

   drv_state_t                      state;
   logic [CNT_W-1:0]                cnt;
   logic [1:0]                      rd_k;
   logic [3:0]                      nxt_idx;
   logic                            wr_a, wr_b;
   logic [N-1:0][DATA_W-1:0]        a_col, b_row, a_q, b_q;
   logic [ELEM_CNT-1:0][ACC_W-1:0]  rbuf;

   assign wr_a    = ld_valid && state == S_IDLE && !ld_sel;
   assign wr_b    = ld_valid && state == S_IDLE &&  ld_sel;
   // Operand outputs are registered, so the banks are read one feed step ahead.
   assign rd_k    = (state == S_FEED) ? 2'(cnt + 1'b1) : 2'd0;
   assign nxt_idx = res_idx + 4'd1;

   operand_bank u_bank_a (
      .clk(clk), .wr_en(wr_a), .wr_idx(ld_idx), .wr_data(ld_data),
      .sel_row(1'b1), .k(rd_k), .rd(a_col)
   );
   operand_bank u_bank_b (
      .clk(clk), .wr_en(wr_b), .wr_idx(ld_idx), .wr_data(ld_data),
      .sel_row(1'b0), .k(rd_k), .rd(b_row)
   );

   assign {arr_a3, arr_a2, arr_a1} = a_q;
   assign {arr_b3, arr_b2, arr_b1} = b_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         arr_rst   <= 1'b1;
         a_q       <= '0;
         b_q       <= '0;
         res_valid <= 1'b0;
         res_idx   <= '0;
         res_last  <= 1'b0;
         res_data  <= '0;
         busy      <= 1'b0;
         ld_ready  <= 1'b1;
      end else begin
         // Zero operands everywhere but FEED keep trailing cycles from accumulating.
         arr_rst <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         case (state)
            S_IDLE: if (start) begin
               state    <= S_CLEAR;
               arr_rst  <= 1'b1;
               busy     <= 1'b1;
               ld_ready <= 1'b0;
            end
            S_CLEAR: begin
               state <= S_FEED;
               cnt   <= '0;
               a_q   <= a_col;
               b_q   <= b_row;
            end
            S_FEED: begin
               if (cnt == CNT_W'(N - 1)) begin
                  state <= S_DRAIN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
                  a_q <= a_col;
                  b_q <= b_row;
               end
            end
            S_DRAIN: begin
               if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                  state     <= S_STREAM;
                  rbuf      <= {arr_c9, arr_c8, arr_c7, arr_c6, arr_c5,
                                arr_c4, arr_c3, arr_c2, arr_c1};
                  res_valid <= 1'b1;
                  res_idx   <= '0;
                  res_last  <= 1'b0;
                  res_data  <= arr_c1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STREAM: if (res_ready) begin
               if (res_last) begin
                  state     <= S_IDLE;
                  res_valid <= 1'b0;
                  res_last  <= 1'b0;
                  res_idx   <= '0;
                  busy      <= 1'b0;
                  ld_ready  <= 1'b1;
               end else begin
                  res_idx  <= nxt_idx;
                  res_data <= rbuf[nxt_idx];
                  res_last <= (nxt_idx == 4'(ELEM_CNT - 1));
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
